dma_prio_rr_arbiter: RTL and testbench

- Next-generation DMA channel arbiter with a parametrised channel count and priority width.
- Strict priority between levels; level 0 is the highest.
- Round-robin between requesters at the same level, replacing fixed lowest-index wins.
- A per-grant hold limit forces re-arbitration, and a grant handover needs no idle bubble.
- Sits between the per-channel request logic and the shared DMA read/write engine; one-hot grant output.

---
 rtl/dma_prio_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_dma_prio_rr_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dma_prio_rr_arbiter.sv
// DMA channel arbiter: strict priority between levels, round-robin within a level,
// with a per-tenure hold limit and zero-bubble grant handover.
module dma_prio_rr_arbiter #(
    parameter  int DMA_CH   = 8,
    parameter  int PRT_W    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = (DMA_CH > 1) ? $clog2(DMA_CH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DMA_CH-1:0]         req_i,
    input  logic [DMA_CH*PRT_W-1:0]   priority_level_i,
    input  logic [DMA_CH-1:0]         lock_i,
    output logic [DMA_CH-1:0]         grant_o,
    output logic                      grant_valid_o,
    output logic [IDX_W-1:0]          grant_idx_o
);

    localparam int                CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(DMA_CH - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state_q, state_nxt;
    logic [DMA_CH-1:0]     grant_q, grant_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]      hold_cnt, hold_cnt_nxt;

    logic                  granted_req, granted_lock, timeout;
    logic [DMA_CH-1:0]     excl, eligible, cand, win_oh;
    logic [PRT_W-1:0]      top_lvl;
    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx, scan_idx;
    int                    scan;

    always_comb begin
        granted_req  = |(req_i & grant_q);
        granted_lock = |(lock_i & grant_q);
        // A request drop takes precedence over a timeout, so exclusion needs the req still high
        timeout      = (MAX_HOLD != 0) && (state_q == GRANT) && (hold_cnt == HOLD_MAX)
                       && !granted_lock && granted_req;
        excl         = timeout ? grant_q : '0;
        eligible     = req_i & ~excl;
    end

    always_comb begin
        top_lvl   = '1;
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        scan      = 0;
        scan_idx  = '0;
        win_oh    = '0;
        for (int i = 0; i < DMA_CH; i++) begin
            if (eligible[i] && (priority_level_i[i*PRT_W +: PRT_W] < top_lvl))
                top_lvl = priority_level_i[i*PRT_W +: PRT_W];
        end
        for (int i = 0; i < DMA_CH; i++)
            cand[i] = eligible[i] && (priority_level_i[i*PRT_W +: PRT_W] == top_lvl);
        // Scan starts just past the last winner so every same-level requester gets a turn
        for (int k = 1; k <= DMA_CH; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= DMA_CH)
                scan = scan - DMA_CH;
            scan_idx = IDX_W'(scan);
            if (!win_valid && cand[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
        if (win_valid)
            win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        state_nxt    = state_q;
        grant_nxt    = grant_q;
        idx_nxt      = idx_q;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_nxt    = GRANT;
                    grant_nxt    = win_oh;
                    idx_nxt      = win_idx;
                    rr_ptr_nxt   = win_idx;
                    hold_cnt_nxt = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!granted_req || timeout) begin
                    if (win_valid) begin
                        grant_nxt    = win_oh;
                        idx_nxt      = win_idx;
                        rr_ptr_nxt   = win_idx;
                        hold_cnt_nxt = CNT_W'(1);
                    end else if (timeout) begin
                        hold_cnt_nxt = CNT_W'(1);
                    end else begin
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        idx_nxt      = '0;
                        hold_cnt_nxt = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt < HOLD_MAX)) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr   <= PTR_RST;
            hold_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            grant_q  <= grant_nxt;
            idx_q    <= idx_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = (state_q == GRANT);
    assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_dma_prio_rr_arbiter.sv
// Directed bench for dma_prio_rr_arbiter (8 channels, hold limit of 4 cycles).
module tb_dma_prio_rr_arbiter;

    logic        clock;
    logic        reset;
    logic [7:0]  req;
    logic [31:0] prioVec;
    logic [7:0]  lock;
    logic [7:0]  grant;
    logic        grantValid;
    logic [2:0]  grantIdx;

    int nChecks = 0;
    int nFails  = 0;

    dma_prio_rr_arbiter #(.DMA_CH(8), .PRT_W(4), .MAX_HOLD(4)) dut (
        .clk_i            (clock),
        .rst_i            (reset),
        .req_i            (req),
        .priority_level_i (prioVec),
        .lock_i           (lock),
        .grant_o          (grant),
        .grant_valid_o    (grantValid),
        .grant_idx_o      (grantIdx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] l);
        req  = r;
        lock = l;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setAllLevels(input logic [3:0] lvl);
        for (int i = 0; i < 8; i++) prioVec[i*4 +: 4] = lvl;
    endtask

    task automatic resetDut();
        applyStimulus(8'h00, 8'h00);
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expGrant);
        logic [2:0] expIdx;
        logic       expValid;
        expIdx   = 3'd0;
        expValid = |expGrant;
        for (int i = 0; i < 8; i++) if (expGrant[i]) expIdx = 3'(i);
        nChecks++;
        assert (grant === expGrant) else begin
            nFails++;
            $error("[TB] FAIL %s grant: observed %h expected %h", tag, grant, expGrant);
        end
        nChecks++;
        assert (grantValid === expValid) else begin
            nFails++;
            $error("[TB] FAIL %s valid: observed %b expected %b", tag, grantValid, expValid);
        end
        nChecks++;
        assert (grantIdx === expIdx) else begin
            nFails++;
            $error("[TB] FAIL %s idx: observed %0d expected %0d", tag, grantIdx, expIdx);
        end
    endtask

    initial begin
        int order[7];
        logic [7:0] expG;
        order = '{1, 3, 6, 1, 3, 6, 1};
        reset = 1'b1;
        applyStimulus(8'h00, 8'h00);
        setAllLevels(4'd3);
        #12;
        checkOutput("reset", 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;

        // Basic grant latency and zero-bubble handover
        applyStimulus(8'h05, 8'h00);
        step(); checkOutput("t1_first", 8'h01);
        applyStimulus(8'h04, 8'h00);
        step(); checkOutput("t1_handover", 8'h04);
        applyStimulus(8'h00, 8'h00);
        step(); checkOutput("t1_idle", 8'h00);

        // Round-robin among channels 1,3,6 at level 2
        resetDut();
        setAllLevels(4'd2);
        applyStimulus(8'h4A, 8'h00);
        step(); checkOutput("t2_first", 8'h02);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(8'h4A, 8'h00);
            step(); checkOutput($sformatf("t2_hold%0da", n), 8'(1 << order[n]));
            step(); checkOutput($sformatf("t2_hold%0db", n), 8'(1 << order[n]));
            applyStimulus(8'h4A & ~8'(1 << order[n]), 8'h00);
            step(); checkOutput($sformatf("t2_next%0d", n), 8'(1 << order[n+1]));
        end

        // No preemption by higher priority; priority decides at re-arbitration
        resetDut();
        setAllLevels(4'd3);
        prioVec[0*4 +: 4] = 4'd5;
        prioVec[7*4 +: 4] = 4'd0;
        prioVec[2*4 +: 4] = 4'd1;
        prioVec[4*4 +: 4] = 4'd1;
        applyStimulus(8'h01, 8'h00);
        step(); checkOutput("t3_ch0", 8'h01);
        applyStimulus(8'h81, 8'h00);
        step(); checkOutput("t3_nopreempt_a", 8'h01);
        step(); checkOutput("t3_nopreempt_b", 8'h01);
        applyStimulus(8'h80, 8'h00);
        step(); checkOutput("t3_ch7", 8'h80);
        applyStimulus(8'h94, 8'h00);
        step(); checkOutput("t3_ch7_hold", 8'h80);
        applyStimulus(8'h14, 8'h00);
        step(); checkOutput("t3_ch2", 8'h04);

        // Hold limit alternates ch2/ch5 every 4 cycles
        resetDut();
        setAllLevels(4'd3);
        applyStimulus(8'h24, 8'h00);
        for (int s = 0; s < 16; s++) begin
            expG = (((s / 4) % 2) == 0) ? 8'h04 : 8'h20;
            step(); checkOutput($sformatf("t4_alt%0d", s), expG);
        end

        // Lock on ch2 suppresses the timeout until its request drops
        resetDut();
        applyStimulus(8'h24, 8'h04);
        for (int s = 0; s < 10; s++) begin
            step(); checkOutput($sformatf("t4_lock%0d", s), 8'h04);
        end
        applyStimulus(8'h20, 8'h04);
        step(); checkOutput("t4_lock_release", 8'h20);

        // Lone requester keeps its grant across timeouts
        resetDut();
        applyStimulus(8'h08, 8'h00);
        for (int s = 0; s < 12; s++) begin
            step(); checkOutput($sformatf("t5_solo%0d", s), 8'h08);
        end

        // Asynchronous reset mid-tenure, then full request set goes to ch0
        @(posedge clock);
        #3 reset = 1'b1;
        #1 checkOutput("t6_async", 8'h00);
        @(posedge clock);
        #4 reset = 1'b0;
        applyStimulus(8'hFF, 8'h00);
        step(); checkOutput("t6_after", 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
